// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and counter sizing for the shift-chain sequencer
package shift_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;
    function automatic int cnt_w(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction
endpackage

// File: rtl/shift_chain_ctrl_if.sv
// shift_chain_ctrl_if: word-in / result-out valid-ready bundle for the shift-chain sequencer
interface shift_chain_ctrl_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_err);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_err);
endinterface

// File: rtl/shift_chain_piso.sv
// shift_chain_piso: parallel-load register serialized MSB-first by rotation
module shift_chain_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             ser_o
);
    logic [WIDTH-1:0] data_q;
    // Rotating rather than shifting leaves the word intact after WIDTH steps.
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else if (load_i) data_q <= data_i;
        else if (shift_i) data_q <= (data_q << 1) | (data_q >> (WIDTH - 1));
    end
    assign data_o = data_q;
    assign ser_o  = data_q[WIDTH-1];
endmodule

// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: clears an external SISO chain, shifts a word through it and returns the loopback
module shift_chain_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    shift_chain_ctrl_if.slave   bus,
    output logic                busy,
    output logic                chain_clr,
    output logic                chain_shift,
    output logic                chain_in,
    input  logic                chain_out
);
    localparam int CNT_W = cnt_w(WIDTH, DEPTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ROT_END = CNT_W'(WIDTH - 1);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] tx, rx_q, rx_d;
    logic             err_q, valid_q, clr_q, shift_q, cin_q, ser, accept, rotate;
    assign accept = state_q == IDLE && bus.in_valid;
    // The CLEAR edge stages bit 0; SHIFT edge k stages bit k+1 while word bits remain.
    assign rotate = state_q == CLEAR || (state_q == SHIFT && cnt_q < ROT_END);
    assign rx_d   = (rx_q << 1) | WIDTH'(chain_out);
    shift_chain_piso #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .shift_i (rotate),
        .data_i  (bus.in_data),
        .data_o  (tx),
        .ser_o   (ser)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            clr_q   <= 1'b0;
            shift_q <= 1'b0;
            cin_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= CLEAR;
                    rx_q    <= '0;
                    clr_q   <= 1'b1;
                end
                CLEAR: begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                    clr_q   <= 1'b0;
                    shift_q <= 1'b1;
                    cin_q   <= ser;
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    cin_q <= rotate ? ser : 1'b0;
                    if (cnt_q >= CAP) rx_q <= rx_d;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        shift_q <= 1'b0;
                        valid_q <= 1'b1;
                        err_q   <= rx_d != tx;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = rx_q;
    assign bus.out_err   = err_q;
    assign busy          = state_q != IDLE;
    assign chain_clr     = clr_q;
    assign chain_shift   = shift_q;
    assign chain_in      = cin_q;
endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb_shift_chain_ctrl: scoreboard bench with chain models for the default and a 4x6 configuration
module tb_shift_chain_ctrl;
    localparam int W = 8, D = 3;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    shift_chain_ctrl_if #(.WIDTH(W)) bus ();
    shift_chain_ctrl_if #(.WIDTH(4)) bus2 ();
    logic busy, clr, sh, cin, cout, busy2, clr2, sh2, cin2, cout2;
    shift_chain_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .chain_clr(clr),
        .chain_shift(sh), .chain_in(cin), .chain_out(cout));
    shift_chain_ctrl #(.WIDTH(4), .DEPTH(6)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .busy(busy2), .chain_clr(clr2),
        .chain_shift(sh2), .chain_in(cin2), .chain_out(cout2));

    logic [D-1:0] chain_q = '0;
    logic [5:0]   chain2_q = '0;
    bit stuck = 1'b0;
    always @(posedge clk) begin
        if (clr) chain_q <= '0;
        else if (sh) chain_q <= {chain_q[D-2:0], cin};
        if (clr2) chain2_q <= '0;
        else if (sh2) chain2_q <= {chain2_q[4:0], cin2};
    end
    assign cout  = stuck ? 1'b0 : chain_q[D-1];
    assign cout2 = chain2_q[5];

    int passed = 0, total = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [W-1:0]   q;
        logic           e;
        logic [W+D-1:0] seq;
        int             acc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    logic [W+D-1:0] cin_log = '0;
    int cin_n = 0, rise_cyc = 0, hs_cyc = 0;
    bit vprev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cin_n = 0;
            cin_log = '0;
            vprev = 1'b0;
        end else begin
            check("ready_vs_busy", bus.in_ready, !busy);
            check("ready_and_valid", bus.in_ready & bus.out_valid, 0);
            if (sh) begin
                cin_log = {cin_log[W+D-2:0], cin};
                cin_n++;
            end
            if (bus.out_valid && !vprev) rise_cyc = cyc;
            vprev = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("out_data", bus.out_data, e.q);
                    check("out_err", bus.out_err, e.e);
                    check("shift_count", cin_n, W + D);
                    check("chain_in_seq", cin_log, e.seq);
                    check("latency", rise_cyc - e.acc, W + D + 1);
                end
                hs_cyc = cyc + 1;
                cin_n = 0;
                cin_log = '0;
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input bit hold, output int acc);
        int n = 0;
        exp_t x;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", n < 300, 1);
        acc = cyc + 1;
        x.q = stuck ? '0 : d;
        x.e = x.q != d;
        x.seq = {d, {D{1'b0}}};
        x.acc = acc;
        if (n < 300) exp_q.push_back(x);
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 300) begin
            @(posedge clk); #1;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            n++;
            @(negedge clk);
        end
        check("done_timeout", n < 300, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int acc, acc2, n, shifts;
        logic [W-1:0] d, sd;
        logic se;
        logic [3:0] v;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_chain_ctl", {clr, sh, cin}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        send(8'hA5, 0, acc);
        wait_done(0);

        send(8'hFF, 1, acc);
        send(8'h00, 0, acc2);
        check("b2b_gap", acc2 - hs_cyc, 1);
        wait_done(0);

        stuck = 1'b1;
        send(8'h3C, 0, acc);
        wait_done(0);
        stuck = 1'b0;

        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        d = 8'($urandom);
        send(d, 0, acc);
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_timeout", n < 50, 1);
        sd = bus.out_data;
        se = bus.out_err;
        check("stall_data_value", sd, d);
        repeat (20) begin
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, sd);
            check("stall_err", bus.out_err, se);
            check("stall_shift", sh, 0);
            check("stall_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_done(0);

        send(8'h5A, 0, acc);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_in_shift", sh, 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_shift", sh, 0);
        check("abort_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        send(8'h81, 0, acc);
        wait_done(0);

        for (int i = 0; i < 12; i++) begin
            stuck = $urandom_range(0, 3) == 0;
            send(8'($urandom), 0, acc);
            wait_done(1);
        end
        stuck = 1'b0;

        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 4'h9 : 4'($urandom);
            @(posedge clk); #1;
            bus2.in_valid = 1'b1;
            bus2.in_data = v;
            @(negedge clk);
            check("w4_in_ready", bus2.in_ready, 1);
            acc = cyc + 1;
            @(posedge clk); #1;
            bus2.in_valid = 1'b0;
            shifts = 0;
            n = 0;
            @(negedge clk);
            while (!bus2.out_valid && n < 60) begin
                if (sh2) shifts++;
                @(negedge clk);
                n++;
            end
            check("w4_shifts", shifts, 10);
            check("w4_latency", cyc - acc, 11);
            check("w4_data", bus2.out_data, v);
            check("w4_err", bus2.out_err, 0);
            @(posedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/shift_chain_ctrl.md
Name: shift_chain_ctrl

Overview:
- Sequencer for an external DEPTH-stage SISO shift chain with shift enable and synchronous clear.
- Accepts a WIDTH-bit word on a valid/ready interface and clears the chain.
- Serializes the word into the chain MSB-first, then flushes with zeros while capturing the chain output.
- Returns the looped-back word plus a mismatch flag on a valid/ready interface; used for chain bring-up and self-test.

Parameters:
- WIDTH, 8, bits per transaction; legal range ≥ 1.
- DEPTH, 3, number of stages in the attached chain; legal range ≥ 1.
- CNT_W, $clog2(WIDTH+DEPTH+1), shift counter width; derived, not for override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  word offered.
- in_ready  out  1  controller can accept a word.
- in_data  in  WIDTH  word to send.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  word captured from the chain.
- out_err  out  1  out_data differs from the word sent.
- busy  out  1  transaction in progress (any state other than IDLE).
- chain_clr  out  1  synchronous clear to the chain.
- chain_shift  out  1  shift enable to the chain.
- chain_in  out  1  serial data into the chain.
- chain_out  in  1  serial output of the chain (last stage).

Behaviour:
- Reset values:
  - Registered: state=IDLE, out_valid=0, out_data=0, out_err=0, chain_clr=0, chain_shift=0, chain_in=0, counter=0.
  - Combinational: in_ready=1 because state=IDLE; busy=0.
  - Reset mid-transaction aborts immediately. No output is produced, and the chain is not shifted further.
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into tx_reg, zero rx_reg, go to CLEAR.
- CLEAR:
  - Exactly one cycle; chain_clr=1, chain_shift=0.
  - Next state SHIFT, counter=0.
- SHIFT: lasts WIDTH+DEPTH cycles, counter k = 0 .. WIDTH+DEPTH-1.
  - chain_shift=1.
  - chain_in = tx_reg[WIDTH-1-k] for k<WIDTH, else 0.
  - chain_out is sampled at each SHIFT edge. It is captured when k≥DEPTH: rx_reg <= {rx_reg[WIDTH-2:0], chain_out}.
  - At the edge with k=WIDTH+DEPTH-1, go to DONE.
- DONE:
  - out_valid=1, out_data=rx_reg, out_err=(rx_reg!=tx_reg).
  - All three are held stable until out_ready.
  - On out_valid&out_ready: go to IDLE, out_valid=0.
- Control outputs: chain_in, chain_shift and chain_clr are driven from registers (or decoded from registered state only). They carry no combinational path from inputs.
- in_ready is 0 in every state except IDLE. It is never asserted in the same cycle as out_valid. A new word can be accepted on the cycle after the out handshake at the earliest.
- Latency: the out_valid rising edge occurs WIDTH+DEPTH+1 edges after the in handshake edge (12 for the defaults).
- Handshake rules:
  - in_data is ignored when in_valid=0.
  - out_ready is ignored outside DONE.
  - in_valid is ignored outside IDLE; a held word is accepted once IDLE is re-entered.
- Counter arithmetic: unsigned. No wrap is possible, because the counter is cleared in CLEAR and its max value WIDTH+DEPTH-1 fits in CNT_W.
- DEPTH>WIDTH is legal: the capture window simply starts after the entire word has been sent.

Decomposition:
- Shared package shift_pkg holds:
  - state enum typedef (IDLE/CLEAR/SHIFT/DONE);
  - localparam helper for CNT_W.
- The chain itself stays external; the bench instantiates a DEPTH-stage chain model.
- One sub-module is natural: shift_chain_piso, the tx_reg parallel-load/serial-out register with load and shift enables, reused by the team's other serializers.
- Capture logic stays inline.

Test Plan:
- Defaults, healthy chain model, send 0xA5, out_ready=1 → chain_in sequence 1,0,1,0,0,1,0,1,0,0,0; out_valid 12 cycles after the accept edge; out_data=0xA5, out_err=0.
- Send 0xFF then 0x00 back-to-back with in_valid held high → in_ready low while busy; second word accepted 1 cycle after the first out handshake; results 0xFF/0x00, err=0.
- Chain model stuck-at-0 on chain_out, send 0x3C → out_data=0x00, out_err=1.
- out_ready held low 20 cycles in DONE → out_valid, out_data and out_err stable; chain_shift=0; in_ready=0 throughout.
- Assert rst during SHIFT at k=4 → next cycle state=IDLE, in_ready=1, chain_shift=0, out_valid=0; a fresh 0x81 then completes correctly with err=0.
- WIDTH=4, DEPTH=6, send 0x9 → 10 SHIFT cycles, capture begins at k=6, out_data=0x9, out_valid 11 edges after accept.
